// File: rtl/slot_unproject.sv
// Scatters N/2 natural-order CKKS slots from the upper FFT half into canonical-embedding
// order in the lower half, conjugating mirrored slots. Optional: SLOT_UNPROJECT_CYCLE_CTR_EN.
module slot_unproject #(
  parameter int unsigned LOGN         = 13,
  parameter int unsigned FLP_WORDSIZE = 64,
  parameter int unsigned BRAM_RD_LAT  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [LOGN-2:0]             fft_rd_addr,
  output logic [LOGN-2:0]             fft_wr_addr,
  output logic                        fft_bank0_wea,
  output logic                        fft_bank1_wea,
  input  logic [2*FLP_WORDSIZE-1:0]   fft_bank0_rd_data,
  input  logic [2*FLP_WORDSIZE-1:0]   fft_bank1_rd_data,
  output logic [2*FLP_WORDSIZE-1:0]   fft_wr_data
`ifdef SLOT_UNPROJECT_CYCLE_CTR_EN
  ,
  output logic [31:0]                 cycle_count
`endif
);

  localparam int unsigned AW    = LOGN - 1;
  localparam int unsigned PW    = LOGN + 1;
  localparam int unsigned DW    = 2 * FLP_WORDSIZE;
  localparam int unsigned SLOTS = 1 << (LOGN - 1);
  localparam int unsigned CW    = (BRAM_RD_LAT > 1) ? $clog2(BRAM_RD_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     j_q, j_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic [CW-1:0]     drain_q, drain_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              issue_c;
  logic              accept_c;

  logic [LOGN-1:0]   idx_c;
  logic [LOGN-1:0]   k_c;
  logic [LOGN-1:0]   a_c;
  logic              conj_c;

  logic [BRAM_RD_LAT-1:0] pipe_vld_q;
  logic [BRAM_RD_LAT-1:0] pipe_conj_q;
  logic [BRAM_RD_LAT-1:0] pipe_sel_q;
  logic [LOGN-1:0]        pipe_a_q [BRAM_RD_LAT];

  logic              wr_vld_c;
  logic [LOGN-1:0]   wr_a_c;
  logic [DW-1:0]     wr_src_c;

  // Destination of the current slot; pos is always odd, so (pos-1)>>1 == pos>>1.
  always_comb begin
    idx_c  = pos_q[LOGN:1];
    k_c    = '0;
    a_c    = '0;
    conj_c = 1'b0;
    for (int i = 0; i < int'(LOGN); i++) begin
      k_c[i] = idx_c[LOGN-1-i];
    end
    if (k_c[LOGN-1]) begin
      a_c    = {LOGN{1'b1}} - k_c;
      conj_c = 1'b1;
    end else begin
      a_c    = k_c;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    pos_d     = pos_q;
    drain_d   = drain_q;
    rd_addr_d = rd_addr_q;
    issue_c   = 1'b0;
    accept_c  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept_c = 1'b1;
          state_d  = S_READ;
          j_d      = '0;
          pos_d    = PW'(1);
        end
      end
      S_READ: begin
        issue_c = 1'b1;
        if (j_q == AW'(SLOTS - 1)) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          j_d   = j_q + AW'(1);
          pos_d = pos_q + {pos_q[PW-2:0], 1'b0};
        end
      end
      S_DRAIN: begin
        if (drain_q == CW'(BRAM_RD_LAT - 1)) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_READ) begin
      rd_addr_d = {1'b1, j_d[AW-1:1]};
    end
    busy_d = (state_d == S_READ) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      j_q       <= '0;
      pos_q     <= PW'(1);
      drain_q   <= '0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      pos_q     <= pos_d;
      drain_q   <= drain_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Destination metadata travels alongside the read so it meets the returning data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q  <= '0;
      pipe_conj_q <= '0;
      pipe_sel_q  <= '0;
      for (int i = 0; i < int'(BRAM_RD_LAT); i++) begin
        pipe_a_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0]  <= issue_c;
      pipe_conj_q[0] <= conj_c;
      pipe_sel_q[0]  <= j_q[0];
      pipe_a_q[0]    <= a_c;
      for (int i = 1; i < int'(BRAM_RD_LAT); i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_conj_q[i] <= pipe_conj_q[i-1];
        pipe_sel_q[i]  <= pipe_sel_q[i-1];
        pipe_a_q[i]    <= pipe_a_q[i-1];
      end
    end
  end

  // Write port driven straight from the last pipeline stage.
  always_comb begin
    wr_vld_c      = pipe_vld_q[BRAM_RD_LAT-1];
    wr_a_c        = pipe_a_q[BRAM_RD_LAT-1];
    wr_src_c      = pipe_sel_q[BRAM_RD_LAT-1] ? fft_bank1_rd_data : fft_bank0_rd_data;
    fft_wr_addr   = {1'b0, wr_a_c[LOGN-2:1]};
    fft_bank0_wea = wr_vld_c & ~wr_a_c[0];
    fft_bank1_wea = wr_vld_c & wr_a_c[0];
    fft_wr_data   = wr_src_c ^ (DW'(pipe_conj_q[BRAM_RD_LAT-1]) << (FLP_WORDSIZE - 1));
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign fft_rd_addr = rd_addr_q;

`ifdef SLOT_UNPROJECT_CYCLE_CTR_EN
  logic [31:0] cyc_cnt_q;

  // Counts busy cycles of the current pass; holds once the pass completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_q <= '0;
    end else if (accept_c) begin
      cyc_cnt_q <= '0;
    end else if (busy_q) begin
      cyc_cnt_q <= cyc_cnt_q + 32'd1;
    end
  end

  assign cycle_count = cyc_cnt_q;
`endif

endmodule
